// File: rtl/alu_sel_sequencer_if.sv
// Request/result bus between an ALU operation source and the select sequencer.
// The sequencer takes the slave modport. The source/consumer takes the master modport.
interface alu_sel_sequencer_if #(
  parameter int K = 7
);
  logic         op_valid;
  logic         op_ready;
  logic [2:0]   opcode;
  logic [6:0]   sel;
  logic [K-1:0] mux_out;
  logic         res_valid;
  logic         res_ready;
  logic [K-1:0] res_data;
  logic         res_err;
  logic [15:0]  ops_done;

  modport master (
    output op_valid, opcode, mux_out, res_ready,
    input  op_ready, sel, res_valid, res_data, res_err, ops_done
  );

  modport slave (
    input  op_valid, opcode, mux_out, res_ready,
    output op_ready, sel, res_valid, res_data, res_err, ops_done
  );
endinterface

// File: rtl/alu_sel_sequencer.sv
// Drives a one-hot ALU output-mux select for one operation at a time.
// It captures the mux result and presents it on a valid/ready result port.
module alu_sel_sequencer #(
  parameter int K        = 7,
  parameter int MULT_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_sel_sequencer_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;

  logic [1:0]   state_q, state_d;
  logic [2:0]   opc_q, opc_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [K-1:0] res_data_q, res_data_d;
  logic         res_err_q, res_err_d;
  logic [15:0]  ops_done_q, ops_done_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    ops_done_d = ops_done_q;
    case (state_q)
      IDLE: begin
        if (bus.op_valid) begin
          if (bus.opcode == OP_ILL) begin
            state_d    = DONE;
            res_err_d  = 1'b1;
            res_data_d = '0;
          end else begin
            state_d = EXEC;
            opc_d   = bus.opcode;
            cnt_d   = (bus.opcode == OP_MUL) ? 4'(MULT_LAT - 1) : 4'd0;
          end
        end
      end
      EXEC: begin
        // Only the last select cycle's mux value is kept; earlier MUL cycles are settling.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          res_data_d = bus.mux_out;
          res_err_d  = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d    = IDLE;
          ops_done_d = sat_inc16(ops_done_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opc_q      <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      opc_q      <= opc_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      ops_done_q <= ops_done_d;
    end
  end

  // The opcode is never 7 in EXEC, so the shifted bit always lands inside the 7-bit select.
  assign bus.sel       = (state_q == EXEC) ? 7'(8'd1 << opc_q) : 7'd0;
  assign bus.op_ready  = rst_n && (state_q == IDLE);
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = res_err_q;
  assign bus.ops_done  = ops_done_q;

endmodule
